// File: rtl/ms_timeout_timer_if.sv
// Call interface of the millisecond deadline timer: start/done handshake,
// command/argument, the time-source count and the timer status outputs.
interface ms_timeout_timer_if #(
  parameter int unsigned DATA_WIDTH = 32
);
  logic                  start_port;
  logic [1:0]            cmd;
  logic [DATA_WIDTH-1:0] arg;
  logic [DATA_WIDTH-1:0] now_ms;
  logic                  done_port;
  logic [DATA_WIDTH-1:0] return_port;
  logic                  expired;

  modport master (
    output start_port, cmd, arg, now_ms,
    input  done_port, return_port, expired
  );

  modport slave (
    input  start_port, cmd, arg, now_ms,
    output done_port, return_port, expired
  );
endinterface

// File: rtl/ms_timeout_timer.sv
// Single-slot millisecond deadline timer with ARM/POLL/CANCEL/WAIT calls;
// all deadline arithmetic is modulo 2^DATA_WIDTH and wrap-safe.
module ms_timeout_timer #(
  parameter int unsigned           DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] MAX_DELAY  = DATA_WIDTH'(2147483647)
) (
  input logic               clock,
  input logic               reset,
  ms_timeout_timer_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StArmed, StExpired} timer_state_e;
  typedef enum logic {StReady, StWaiting} call_state_e;

  localparam logic [1:0] CmdArm    = 2'd0;
  localparam logic [1:0] CmdPoll   = 2'd1;
  localparam logic [1:0] CmdCancel = 2'd2;
  localparam logic [1:0] CmdWait   = 2'd3;

  timer_state_e          timer_q, timer_d;
  call_state_e           call_q, call_d;
  logic [DATA_WIDTH-1:0] deadline_q, deadline_d;
  logic [DATA_WIDTH-1:0] return_q, return_d;
  logic                  done_q, done_d;
  logic                  expired_q;

  logic [DATA_WIDTH-1:0] diff;
  logic                  reached;
  logic [DATA_WIDTH-1:0] remaining;
  logic [DATA_WIDTH-1:0] arg_sat;
  logic                  accept;

  // Signed view of (now - deadline): non-negative means the deadline has passed,
  // which stays correct across wrap of now_ms.
  assign diff      = bus.now_ms - deadline_q;
  assign reached   = ~diff[DATA_WIDTH-1];
  assign remaining = (timer_q == StArmed && !reached) ? (deadline_q - bus.now_ms) : '0;
  assign arg_sat   = (bus.arg > MAX_DELAY) ? MAX_DELAY : bus.arg;
  assign accept    = bus.start_port && (call_q == StReady);

  always_comb begin
    timer_d    = timer_q;
    deadline_d = deadline_q;
    if (timer_q == StArmed && reached) begin
      timer_d = StExpired;
    end
    // A call in the expiry cycle overrides the expiry transition.
    if (accept && bus.cmd == CmdArm) begin
      deadline_d = bus.now_ms + arg_sat;
      timer_d    = StArmed;
    end else if (accept && bus.cmd == CmdCancel) begin
      timer_d = StIdle;
    end
  end

  always_comb begin
    call_d   = call_q;
    done_d   = 1'b0;
    return_d = return_q;
    case (call_q)
      StReady: begin
        if (bus.start_port) begin
          unique case (bus.cmd)
            CmdArm: begin
              done_d   = 1'b1;
              return_d = arg_sat;
            end
            CmdPoll, CmdCancel: begin
              done_d   = 1'b1;
              return_d = remaining;
            end
            CmdWait: begin
              if (timer_q == StArmed && !reached) begin
                call_d = StWaiting;
              end else begin
                done_d   = 1'b1;
                return_d = '0;
              end
            end
          endcase
        end
      end
      StWaiting: begin
        if (timer_q != StArmed || reached) begin
          call_d   = StReady;
          done_d   = 1'b1;
          return_d = '0;
        end
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      timer_q    <= StIdle;
      call_q     <= StReady;
      deadline_q <= '0;
      return_q   <= '0;
      done_q     <= 1'b0;
      expired_q  <= 1'b0;
    end else begin
      timer_q    <= timer_d;
      call_q     <= call_d;
      deadline_q <= deadline_d;
      return_q   <= return_d;
      done_q     <= done_d;
      expired_q  <= (timer_d == StExpired);
    end
  end

  assign bus.done_port   = done_q;
  assign bus.return_port = return_q;
  assign bus.expired     = expired_q;

endmodule

// File: tb/tb_ms_timeout_timer.sv
// Directed bench for ms_timeout_timer: hand-computed results for each call,
// expiry, wrap, WAIT completion and reset abort.
module tb_ms_timeout_timer;

  localparam logic [1:0] CmdArm    = 2'd0;
  localparam logic [1:0] CmdPoll   = 2'd1;
  localparam logic [1:0] CmdCancel = 2'd2;
  localparam logic [1:0] CmdWait   = 2'd3;

  logic clock;
  logic reset;
  int   n_cmp;
  int   n_err;
  logic seen_done;

  ms_timeout_timer_if #(.DATA_WIDTH(32)) bus ();

  ms_timeout_timer #(.DATA_WIDTH(32)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issues one start pulse; returns one cycle later, when done should be visible.
  task automatic call(input logic [1:0] c, input logic [31:0] a);
    bus.start_port = 1'b1;
    bus.cmd        = c;
    bus.arg        = a;
    step();
    bus.start_port = 1'b0;
  endtask

  initial begin
    n_cmp          = 0;
    n_err          = 0;
    reset          = 1'b0;
    bus.start_port = 1'b0;
    bus.cmd        = CmdPoll;
    bus.arg        = '0;
    bus.now_ms     = '0;
    repeat (3) step();
    check("rst_done", 32'(bus.done_port), 32'd0);
    check("rst_ret", bus.return_port, 32'd0);
    check("rst_exp", 32'(bus.expired), 32'd0);
    reset = 1'b1;
    step();
    check("idle_done", 32'(bus.done_port), 32'd0);

    call(CmdPoll, 32'd0);
    check("poll0_done", 32'(bus.done_port), 32'd1);
    check("poll0_ret", bus.return_port, 32'd0);
    step();
    check("poll0_single", 32'(bus.done_port), 32'd0);

    // Basic expiry at deadline 1005
    bus.now_ms = 32'd1000;
    call(CmdArm, 32'd5);
    check("arm5_done", 32'(bus.done_port), 32'd1);
    check("arm5_ret", bus.return_port, 32'd5);
    bus.now_ms = 32'd1004;
    step();
    check("arm5_done_once", 32'(bus.done_port), 32'd0);
    check("exp_1004", 32'(bus.expired), 32'd0);
    bus.now_ms = 32'd1005;
    step();
    check("exp_1005", 32'(bus.expired), 32'd1);
    call(CmdPoll, 32'd0);
    check("poll_exp_done", 32'(bus.done_port), 32'd1);
    check("poll_exp_ret", bus.return_port, 32'd0);

    // Wrap: deadline 0xFFFFFFFE + 4 = 2
    bus.now_ms = 32'hFFFF_FFFE;
    call(CmdArm, 32'd4);
    check("wrap_arm_ret", bus.return_port, 32'd4);
    check("wrap_arm_exp", 32'(bus.expired), 32'd0);
    bus.now_ms = 32'hFFFF_FFFF;
    call(CmdPoll, 32'd0);
    check("wrap_poll_ret", bus.return_port, 32'd3);
    check("wrap_poll_exp", 32'(bus.expired), 32'd0);
    bus.now_ms = 32'd2;
    step();
    check("wrap_exp", 32'(bus.expired), 32'd1);

    // WAIT on deadline 100; a start during WAITING must be ignored
    bus.now_ms = 32'd0;
    call(CmdArm, 32'd100);
    check("w_arm_ret", bus.return_port, 32'd100);
    bus.now_ms = 32'd10;
    call(CmdWait, 32'd0);
    seen_done = bus.done_port;
    for (int t = 11; t < 100; t++) begin
      bus.now_ms = 32'(t);
      if (t == 50) begin
        call(CmdArm, 32'd7);
      end else begin
        step();
      end
      seen_done = seen_done | bus.done_port;
    end
    check("w_no_early_done", 32'(seen_done), 32'd0);
    check("w_ret_held", bus.return_port, 32'd100);
    bus.now_ms = 32'd100;
    step();
    check("w_done", 32'(bus.done_port), 32'd1);
    check("w_ret", bus.return_port, 32'd0);
    check("w_exp", 32'(bus.expired), 32'd1);
    step();
    check("w_done_once", 32'(bus.done_port), 32'd0);

    // CANCEL returns remaining, then WAIT on IDLE completes at once
    bus.now_ms = 32'd0;
    call(CmdArm, 32'd50);
    check("c_arm_ret", bus.return_port, 32'd50);
    bus.now_ms = 32'd20;
    call(CmdCancel, 32'd0);
    check("c_done", 32'(bus.done_port), 32'd1);
    check("c_ret", bus.return_port, 32'd30);
    check("c_exp", 32'(bus.expired), 32'd0);
    call(CmdWait, 32'd0);
    check("c_wait_done", 32'(bus.done_port), 32'd1);
    check("c_wait_ret", bus.return_port, 32'd0);
    call(CmdArm, 32'hFFFF_FFFF);
    check("sat_ret", bus.return_port, 32'h7FFF_FFFF);

    // Reset aborts a pending WAIT
    call(CmdWait, 32'd0);
    check("rw_wait_pending", 32'(bus.done_port), 32'd0);
    step();
    step();
    reset = 1'b0;
    step();
    check("rw_done", 32'(bus.done_port), 32'd0);
    check("rw_ret", bus.return_port, 32'd0);
    check("rw_exp", 32'(bus.expired), 32'd0);
    reset = 1'b1;
    step();
    check("rw_no_late_done", 32'(bus.done_port), 32'd0);
    call(CmdArm, 32'd1);
    check("rw_arm_ret", bus.return_port, 32'd1);
    check("rw_arm_exp", 32'(bus.expired), 32'd0);
    bus.now_ms = 32'd21;
    step();
    check("rw_arm_expired", 32'(bus.expired), 32'd1);

    // ARM in the expiry cycle wins; POLL in the expiry cycle returns 0
    bus.now_ms = 32'd2000;
    call(CmdArm, 32'd5);
    bus.now_ms = 32'd2005;
    call(CmdArm, 32'd3);
    check("sim_arm_ret", bus.return_port, 32'd3);
    check("sim_arm_exp", 32'(bus.expired), 32'd0);
    step();
    check("sim_arm_exp2", 32'(bus.expired), 32'd0);
    bus.now_ms = 32'd2008;
    call(CmdPoll, 32'd0);
    check("sim_poll_ret", bus.return_port, 32'd0);
    check("sim_poll_exp", 32'(bus.expired), 32'd1);

    // ARM with zero delay expires on the following cycle
    bus.now_ms = 32'd3000;
    call(CmdArm, 32'd0);
    check("zero_exp_now", 32'(bus.expired), 32'd0);
    step();
    check("zero_exp_next", 32'(bus.expired), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ms_timeout_timer.md
Name: ms_timeout_timer

Overview:
- Millisecond deadline timer that consumes the free-running millisecond count produced by the time-source block on now_ms.
- Gives the XVC server software sleep, timeout polling and cancel primitives through the same start/done call interface used by the other HLS-called hardware functions.
- Used for TCP idle timeouts and JTAG shift pacing.
- One deadline slot; all deadline arithmetic is wrap-around safe.

Parameters:
- DATA_WIDTH, 32: width of now_ms, arg and return_port.
- MAX_DELAY, 2147483647: largest accepted delay in ms; larger arg values saturate to this.

Ports:
- clock  input  1  system clock, 200 MHz.
- reset  input  1  synchronous, active-low.
- start_port  input  1  call strobe; samples cmd and arg.
- cmd  input  2  0=ARM, 1=POLL, 2=CANCEL, 3=WAIT.
- arg  input  DATA_WIDTH  delay in ms; used by ARM only.
- now_ms  input  DATA_WIDTH  current millisecond count from the time source; monotonic and wraps at 2^32.
- done_port  output  1  one-cycle call-completion pulse.
- return_port  output  DATA_WIDTH  call result; valid when done_port=1, held until the next done.
- expired  output  1  level; high while the timer state is EXPIRED.

Behaviour:
Reset:
- The block is reset when reset=0 at a clock edge. Reset has priority over everything and aborts any pending WAIT without a done pulse.
- Reset values: done_port=0, return_port=0, expired=0, timer state IDLE, call state READY, deadline=0.

Timer FSM (IDLE, ARMED, EXPIRED):
- IDLE -> ARMED on ARM.
- ARMED -> EXPIRED when the signed DATA_WIDTH-bit value (now_ms - deadline) is >= 0. This is evaluated every cycle, so wrap of now_ms is handled correctly.
- ARMED or EXPIRED -> IDLE on CANCEL.
- ARM in any state re-arms: deadline = now_ms + min(arg, MAX_DELAY), computed modulo 2^DATA_WIDTH, and the state goes to ARMED.
- ARM with arg=0 enters ARMED; the expiry check moves it to EXPIRED on the following cycle.
- expired is a registered decode of state EXPIRED.

Remaining time:
- remaining = deadline - now_ms when the state is ARMED and not yet expired; otherwise 0.

Call FSM (READY, WAITING):
- start_port is sampled only in READY. In WAITING it is ignored, with no queueing.
- ARM: done_port pulses 1 cycle after start; return_port = min(arg, MAX_DELAY).
- POLL: done_port pulses 1 cycle after start; return_port = remaining, evaluated with the start-cycle now_ms.
- CANCEL: done_port pulses 1 cycle after start; return_port = remaining before the cancel; the state becomes IDLE.
- WAIT when the timer is IDLE or EXPIRED: done_port pulses 1 cycle after start; return_port = 0.
- WAIT when the timer is ARMED: the call state goes to WAITING. done_port pulses 1 cycle after the cycle in which the timer enters EXPIRED; return_port = 0. The call state then returns to READY.
- done_port is high for exactly one cycle per accepted call.

Simultaneous events:
- An ARM start in the same cycle as the expiry condition: the ARM wins and the state is ARMED with the new deadline.
- A POLL start in the expiry cycle returns 0.
- now_ms jumping by more than 1 between cycles is legal; the expiry compare handles it.

Test Plan:
- Apply reset=0 for 3 cycles, then reset=1 -> done_port=0, return_port=0, expired=0; a POLL returns 0 with done 1 cycle later.
- now_ms=1000; ARM arg=5 -> done+1 with return 5. Step now_ms to 1004 -> expired=0. At now_ms=1005 -> expired=1 one cycle later. A POLL then returns 0.
- Wrap case: now_ms=0xFFFFFFFE, ARM arg=4 -> deadline=2. At now_ms=0xFFFFFFFF a POLL returns 3 and expired=0. At now_ms=2 -> expired=1.
- ARM arg=100 at now_ms=0. Issue WAIT at now_ms=10 -> no done through now_ms=99. Step now_ms to 100 -> done pulses exactly once, return 0. A start_port pulse during WAITING produces no extra done.
- ARM arg=50 at now_ms=0. CANCEL at now_ms=20 -> return 30 and state IDLE. A subsequent WAIT completes in 1 cycle with return 0. ARM arg=0xFFFFFFFF returns 2147483647.
- Issue WAIT while ARMED, then assert reset=0 mid-wait -> no done pulse, all outputs at reset values. After release, an ARM arg=1 works normally.
